// File: rtl/data_mem_bhw.sv
// Byte-addressable MEM-stage data memory with byte/half/word access,
// misalignment suppression and a handshaked sequential debug dump port.
module data_mem_bhw #(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [1:0]   i_size,
    input  logic         i_unsigned,
    input  logic [W-1:0] i_addr,
    input  logic [B-1:0] i_data,
    output logic [B-1:0] o_data,
    output logic         o_misaligned,
    input  logic         i_dbg_start,
    input  logic         i_dbg_ready,
    output logic         o_dbg_valid,
    output logic [W-3:0] o_dbg_addr,
    output logic [B-1:0] o_dbg_data,
    output logic         o_dbg_done
);

    // Dump FSM
    // state   | meaning
    // ST_IDLE | waiting for i_dbg_start
    // ST_SCAN | presenting mem[idx_q], advancing on each accepted word
    // ST_DONE | one-cycle done pulse, then back to idle

    localparam int NW = 1 << (W - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    logic [B-1:0] mem_q [NW];
    logic [W-3:0] widx;
    logic [B-1:0] word;
    logic [7:0]   byte_lane;
    logic [15:0]  half_lane;
    logic [B-1:0] wdata_d;
    logic         we;

    state_t       state_q;
    logic [W-3:0] idx_q;
    logic         valid_q;
    logic         done_q;

    assign widx = i_addr[W-1:2];
    assign word = mem_q[widx];
    assign we   = i_mem_write & ~o_misaligned;

    // Fault detection only matters while an access is actually requested.
    always_comb begin
        o_misaligned = 1'b0;
        if (i_mem_read || i_mem_write) begin
            case (i_size)
                2'b00:   o_misaligned = 1'b0;
                2'b01:   o_misaligned = i_addr[0];
                2'b10:   o_misaligned = (i_addr[1:0] != 2'b00);
                default: o_misaligned = 1'b1;
            endcase
        end
    end

    // Lane selection and extension for loads (zero-cycle, reads old contents).
    always_comb begin
        case (i_addr[1:0])
            2'b00:   byte_lane = word[7:0];
            2'b01:   byte_lane = word[15:8];
            2'b10:   byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = i_addr[1] ? word[31:16] : word[15:0];
        o_data = '0;
        if (i_mem_read && !o_misaligned) begin
            case (i_size)
                2'b00:   o_data = i_unsigned ? {{(B-8){1'b0}}, byte_lane}
                                             : {{(B-8){byte_lane[7]}}, byte_lane};
                2'b01:   o_data = i_unsigned ? {{(B-16){1'b0}}, half_lane}
                                             : {{(B-16){half_lane[15]}}, half_lane};
                default: o_data = word;
            endcase
        end
    end

    // Merge store data into only the addressed lanes of the current word.
    always_comb begin
        wdata_d = word;
        case (i_size)
            2'b00: begin
                case (i_addr[1:0])
                    2'b00:   wdata_d[7:0]   = i_data[7:0];
                    2'b01:   wdata_d[15:8]  = i_data[7:0];
                    2'b10:   wdata_d[23:16] = i_data[7:0];
                    default: wdata_d[31:24] = i_data[7:0];
                endcase
            end
            2'b01: begin
                if (i_addr[1]) wdata_d[31:16] = i_data[15:0];
                else           wdata_d[15:0]  = i_data[15:0];
            end
            2'b10:   wdata_d = i_data;
            default: wdata_d = word;
        endcase
    end

    // Memory array: cleared on reset, written by aligned stores.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NW; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[widx] <= wdata_d;
        end
    end

    // Dump sequencer with registered valid/done and word index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_dbg_start) begin
                        state_q <= ST_SCAN;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (valid_q && i_dbg_ready) begin
                        if (idx_q == {(W-2){1'b1}}) begin
                            state_q <= ST_DONE;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_valid = valid_q;
    assign o_dbg_addr  = idx_q;
    assign o_dbg_data  = mem_q[idx_q];
    assign o_dbg_done  = done_q;

endmodule

// File: tb/tb_data_mem_bhw.sv
// Directed bench for data_mem_bhw: lane stores/loads, faults, dump and reset abort.
module tb_data_mem_bhw;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [9:0]  i_addr;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        o_misaligned;
    logic        i_dbg_start;
    logic        i_dbg_ready;
    logic        o_dbg_valid;
    logic [7:0]  o_dbg_addr;
    logic [31:0] o_dbg_data;
    logic        o_dbg_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_mem [256];

    data_mem_bhw #(.B(32), .W(10)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_misaligned (o_misaligned),
        .i_dbg_start  (i_dbg_start),
        .i_dbg_ready  (i_dbg_ready),
        .o_dbg_valid  (o_dbg_valid),
        .o_dbg_addr   (o_dbg_addr),
        .o_dbg_data   (o_dbg_data),
        .o_dbg_done   (o_dbg_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge i_clk);
        i_addr = a; i_size = sz; i_data = d; i_mem_write = 1'b1; i_mem_read = 1'b0;
        @(posedge i_clk);
        #1 i_mem_write = 1'b0;
    endtask

    task automatic load(input logic [9:0] a, input logic [1:0] sz, input logic uns,
                        output logic [31:0] d, output logic mis);
        @(negedge i_clk);
        i_addr = a; i_size = sz; i_unsigned = uns; i_mem_read = 1'b1; i_mem_write = 1'b0;
        #1;
        d = o_data; mis = o_misaligned;
        i_mem_read = 1'b0;
    endtask

    logic [31:0] rd;
    logic        mis;
    int          widx;
    int          done_cnt;
    int          post_done;
    bit          found;

    initial begin
        i_reset = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'b10;
        i_unsigned = 1'b0; i_addr = '0; i_data = '0; i_dbg_start = 1'b0; i_dbg_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("rst_o_data", o_data, 32'h0);
        check("rst_misaligned", {31'b0, o_misaligned}, 32'h0);
        check("rst_dbg_valid", {31'b0, o_dbg_valid}, 32'h0);
        check("rst_dbg_addr", {24'b0, o_dbg_addr}, 32'h0);
        check("rst_dbg_data", o_dbg_data, 32'h0);
        check("rst_dbg_done", {31'b0, o_dbg_done}, 32'h0);

        for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;

        for (int i = 0; i < 10; i++) begin
            store(10'(i * 4), 2'b10, 32'(i));
            exp_mem[i] = 32'(i);
        end
        for (int i = 0; i < 10; i++) begin
            load(10'(i * 4), 2'b10, 1'b0, rd, mis);
            check($sformatf("lw_%0d", i), rd, 32'(i));
            check($sformatf("lw_mis_%0d", i), {31'b0, mis}, 32'h0);
        end

        store(10'h10, 2'b10, 32'h11223344);
        store(10'h12, 2'b00, 32'hFFFFFFAA);
        exp_mem[4] = 32'h11AA3344;
        load(10'h10, 2'b10, 1'b0, rd, mis); check("lw_10", rd, 32'h11AA3344);
        load(10'h12, 2'b00, 1'b0, rd, mis); check("lb_12", rd, 32'hFFFFFFAA);
        load(10'h12, 2'b00, 1'b1, rd, mis); check("lbu_12", rd, 32'h000000AA);
        load(10'h12, 2'b01, 1'b0, rd, mis); check("lh_12", rd, 32'h000011AA);
        load(10'h13, 2'b00, 1'b1, rd, mis); check("lbu_13", rd, 32'h00000011);

        store(10'h20, 2'b01, 32'h00008001);
        exp_mem[8] = 32'h00008001;
        load(10'h20, 2'b01, 1'b0, rd, mis); check("lh_20", rd, 32'hFFFF8001);
        load(10'h20, 2'b01, 1'b1, rd, mis); check("lhu_20", rd, 32'h00008001);

        @(negedge i_clk);
        i_addr = 10'h21; i_size = 2'b01; i_data = 32'h0000BEEF; i_mem_write = 1'b1;
        #1 check("sh_21_mis", {31'b0, o_misaligned}, 32'h1);
        @(posedge i_clk); #1 i_mem_write = 1'b0;
        load(10'h20, 2'b10, 1'b0, rd, mis); check("w20_unchanged", rd, 32'h00008001);
        load(10'h22, 2'b10, 1'b0, rd, mis);
        check("lw_22_mis", {31'b0, mis}, 32'h1);
        check("lw_22_data", rd, 32'h0);

        @(negedge i_clk);
        i_addr = 10'h24; i_size = 2'b11; i_data = 32'hDEADBEEF; i_mem_write = 1'b1;
        #1 check("sz11_mis", {31'b0, o_misaligned}, 32'h1);
        @(posedge i_clk); #1 i_mem_write = 1'b0;
        load(10'h24, 2'b10, 1'b0, rd, mis); check("w24_unchanged", rd, 32'h9);

        @(negedge i_clk);
        i_addr = 10'h24; i_size = 2'b10; i_mem_read = 1'b0; i_mem_write = 1'b0;
        #1;
        check("idle_mis", {31'b0, o_misaligned}, 32'h0);
        check("idle_data", o_data, 32'h0);

        // Read and write together: old contents now, new contents next cycle.
        @(negedge i_clk);
        i_addr = 10'h28; i_size = 2'b10; i_data = 32'h00000055; i_mem_read = 1'b1; i_mem_write = 1'b1;
        #1 check("rw_old", o_data, 32'h0);
        @(posedge i_clk); #1 i_mem_write = 1'b0;
        @(negedge i_clk); #1 check("rw_new", o_data, 32'h55);
        i_mem_read = 1'b0;
        exp_mem[10] = 32'h55;

        // Full dump with ready toggling every other cycle.
        @(negedge i_clk); i_dbg_start = 1'b1;
        @(posedge i_clk); #1 i_dbg_start = 1'b0;
        widx = 0; done_cnt = 0; post_done = 0;
        for (int cyc = 0; cyc < 1500 && post_done < 4; cyc++) begin
            @(negedge i_clk);
            i_dbg_ready = cyc[0];
            #1;
            if (o_dbg_done) begin
                done_cnt++;
                check("done_after_last", 32'(widx), 32'd256);
                check("done_valid_low", {31'b0, o_dbg_valid}, 32'h0);
            end
            if (done_cnt > 0) post_done++;
            if (o_dbg_valid) begin
                check("dump_addr", {24'b0, o_dbg_addr}, 32'(widx));
                check("dump_data", o_dbg_data, exp_mem[widx[7:0]]);
                if (i_dbg_ready) widx++;
            end
        end
        i_dbg_ready = 1'b0;
        check("dump_words", 32'(widx), 32'd256);
        check("dump_done_cnt", 32'(done_cnt), 32'd1);
        check("dump_idle_valid", {31'b0, o_dbg_valid}, 32'h0);

        // Reset in the middle of a dump.
        @(negedge i_clk); i_dbg_start = 1'b1;
        @(posedge i_clk); #1 i_dbg_start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge i_clk);
            i_dbg_ready = 1'b1;
            #1;
            if (o_dbg_valid && o_dbg_addr == 8'd5) found = 1'b1;
        end
        check("reached_idx5", {31'b0, found}, 32'h1);
        i_reset = 1'b1; i_dbg_ready = 1'b0;
        @(posedge i_clk); #1 i_reset = 1'b0;
        check("abort_valid", {31'b0, o_dbg_valid}, 32'h0);
        check("abort_done", {31'b0, o_dbg_done}, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            load(10'(i * 4), 2'b10, 1'b0, rd, mis);
            if (o_dbg_done) done_cnt++;
            check($sformatf("clr_%0d", i), rd, 32'h0);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
